// File: rtl/clock_time_keeper_if.sv
// Bus bundle between the time keeper and its neighbours (enable generator, buttons, display).
// The pm signal exists only when CLOCK_12H_EN is defined.
interface clock_time_keeper_if;
  logic       hit;
  logic       btn_mode;
  logic       btn_inc;
  logic       clear;
  logic [1:0] set_mode;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       blink;
`ifdef CLOCK_12H_EN
  logic       pm;

  modport master (output hit, btn_mode, btn_inc,
                  input  clear, set_mode, hours, minutes, seconds, blink, pm);
  modport slave  (input  hit, btn_mode, btn_inc,
                  output clear, set_mode, hours, minutes, seconds, blink, pm);
`else
  modport master (output hit, btn_mode, btn_inc,
                  input  clear, set_mode, hours, minutes, seconds, blink);
  modport slave  (input  hit, btn_mode, btn_inc,
                  output clear, set_mode, hours, minutes, seconds, blink);
`endif
endinterface

// File: rtl/clock_time_keeper.sv
// Time-of-day keeper with RUN / SET_HOUR / SET_MIN modes and auto-repeat increment.
// Define CLOCK_12H_EN for 12-hour display (hours 1..12 plus pm flag).
module clock_time_keeper #(
  parameter int HOLD_DELAY   = 2,
  parameter int HITS_PER_SEC = 2
) (
  input  logic ck,
  input  logic reset,
  clock_time_keeper_if.slave bus
);
  localparam int PW = (HITS_PER_SEC > 1) ? $clog2(HITS_PER_SEC) : 1;
  localparam int RW = (HOLD_DELAY > 0) ? $clog2(HOLD_DELAY + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HITS_PER_SEC - 1);
  localparam logic [RW-1:0] REP_LIMIT  = RW'(HOLD_DELAY);
`ifdef CLOCK_12H_EN
  localparam logic [4:0] HOUR_RESET = 5'd12;
`else
  localparam logic [4:0] HOUR_RESET = 5'd0;
`endif

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    BAD      = 2'b11
  } mode_e;

  mode_e          state_q, state_d;
  logic [4:0]     hours_q, hours_d;
  logic [5:0]     min_q, min_d;
  logic [5:0]     sec_q, sec_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [RW-1:0]  rep_q, rep_d;
  logic           mode_q, inc_q, live_q;
  logic           clear_q, clear_d;
  logic           blink_q, blink_d;
  logic           bump_field, bump_hour;
  logic           mode_rise, inc_rise;
`ifdef CLOCK_12H_EN
  logic           pm_q, pm_d;
`endif

  // live_q masks the first cycle after reset so a button held through reset is not an edge.
  assign mode_rise = bus.btn_mode & ~mode_q & live_q;
  assign inc_rise  = bus.btn_inc  & ~inc_q  & live_q;

  function automatic logic [4:0] hour_next(input logic [4:0] h);
`ifdef CLOCK_12H_EN
    return (h == 5'd12) ? 5'd1 : h + 5'd1;
`else
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
`endif
  endfunction

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      hours_q <= HOUR_RESET;
      min_q   <= '0;
      sec_q   <= '0;
      phase_q <= '0;
      rep_q   <= '0;
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
      live_q  <= 1'b0;
      clear_q <= 1'b0;
      blink_q <= 1'b0;
`ifdef CLOCK_12H_EN
      pm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      mode_q  <= bus.btn_mode;
      inc_q   <= bus.btn_inc;
      live_q  <= 1'b1;
      clear_q <= clear_d;
      blink_q <= blink_d;
`ifdef CLOCK_12H_EN
      pm_q    <= pm_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    min_d      = min_q;
    sec_d      = sec_q;
    phase_d    = phase_q;
    rep_d      = rep_q;
    clear_d    = 1'b0;
    blink_d    = blink_q;
    bump_field = 1'b0;
    bump_hour  = 1'b0;
`ifdef CLOCK_12H_EN
    pm_d       = pm_q;
`endif
    case (state_q)
      RUN: begin
        blink_d = 1'b0;
        rep_d   = '0;
        if (mode_rise) begin
          state_d = SET_HOUR;
          clear_d = 1'b1;
        end else if (bus.hit) begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            if (sec_q == 6'd59) begin
              sec_d = '0;
              if (min_q == 6'd59) begin
                min_d     = '0;
                bump_hour = 1'b1;
              end else begin
                min_d = min_q + 6'd1;
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      SET_HOUR, SET_MIN: begin
        if (mode_rise) begin
          blink_d = 1'b0;
          rep_d   = '0;
          if (state_q == SET_HOUR) begin
            state_d = SET_MIN;
          end else begin
            state_d = RUN;
            clear_d = 1'b1;
            sec_d   = '0;
            phase_d = '0;
          end
        end else if (inc_rise) begin
          bump_field = 1'b1;
          rep_d      = '0;
          clear_d    = 1'b1;
          blink_d    = 1'b1;
        end else if (bus.btn_inc && bus.hit) begin
          // Hold-off hits count up first; only after HOLD_DELAY of them does the field repeat.
          if (rep_q < REP_LIMIT) begin
            rep_d   = rep_q + 1'b1;
            blink_d = ~blink_q;
          end else begin
            bump_field = 1'b1;
            blink_d    = 1'b1;
          end
        end else if (bus.hit) begin
          blink_d = ~blink_q;
        end
        if (!bus.btn_inc) rep_d = '0;
      end
      default: begin
        state_d = RUN;
        blink_d = 1'b0;
        rep_d   = '0;
      end
    endcase

    if (bump_field) begin
      if (state_q == SET_HOUR) bump_hour = 1'b1;
      else                     min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end
    if (bump_hour) begin
      hours_d = hour_next(hours_q);
`ifdef CLOCK_12H_EN
      if (hours_q == 5'd11) pm_d = ~pm_q;
`endif
    end
  end

  assign bus.clear    = clear_q;
  assign bus.set_mode = state_q;
  assign bus.hours    = hours_q;
  assign bus.minutes  = min_q;
  assign bus.seconds  = sec_q;
  assign bus.blink    = blink_q;
`ifdef CLOCK_12H_EN
  assign bus.pm       = pm_q;
`endif
endmodule
